// File: rtl/ps2_note_ctrl_if.sv
// Byte handshake between the PS/2 receiver FIFO (master) and the note controller (slave).
interface ps2_note_ctrl_if;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       nextdata_n;

    modport master (output data, ready, overflow, input nextdata_n);
    modport slave  (input data, ready, overflow, output nextdata_n);
endinterface

// File: rtl/ps2_note_ctrl.sv
// PS/2 scan-code to phase-increment controller with last-pressed-priority key stack.
// Optional portamento on freq when NOTE_GLIDE_EN is defined.
module ps2_note_ctrl #(
    parameter int STACK_DEPTH = 4,
    parameter int FS_HZ       = 48000
) (
    input  logic               clk,
    input  logic               clrn,
    ps2_note_ctrl_if.slave     bus,
    output logic [15:0]        freq,
    output logic [3:0]         key_cnt,
    output logic signed [1:0]  octave,
    output logic               ovf_seen
);
    localparam int IW = (STACK_DEPTH > 2) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [63:0] FS_MHZ = 64'(FS_HZ) * 64'd1000;

    // Note frequencies given in millihertz so the table rounds exactly in integer math.
    function automatic logic [15:0] note_inc(input logic [63:0] f_mhz);
        logic [63:0] q;
        q = (f_mhz * 64'd65536 + FS_MHZ / 64'd2) / FS_MHZ;
        return q[15:0];
    endfunction

    localparam logic [15:0] INC_C = note_inc(64'd261626);
    localparam logic [15:0] INC_D = note_inc(64'd293665);
    localparam logic [15:0] INC_E = note_inc(64'd329628);
    localparam logic [15:0] INC_F = note_inc(64'd349228);
    localparam logic [15:0] INC_G = note_inc(64'd391995);
    localparam logic [15:0] INC_A = note_inc(64'd440000);
    localparam logic [15:0] INC_B = note_inc(64'd493883);

    typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_UPD} state_t;

    state_t      state_q, state_d;
    logic        pop_q;
    logic        accept, do_make, do_break;
    logic [2:0]  stack_q [STACK_DEPTH];
    logic [2:0]  stack_d [STACK_DEPTH];
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  oct_q, oct_d;
    logic        ovf_q;
    logic [15:0] freq_q, freq_calc, base;
    logic        note_vld;
    logic [2:0]  note_idx;
    logic [STACK_DEPTH-1:0] hit;
    logic [IW-1:0] hit_pos;
    logic [3:0]  top_idx;

    always_comb begin
        note_vld = 1'b1;
        note_idx = 3'd0;
        case (bus.data)
            8'h1C: note_idx = 3'd0;
            8'h1B: note_idx = 3'd1;
            8'h23: note_idx = 3'd2;
            8'h2B: note_idx = 3'd3;
            8'h34: note_idx = 3'd4;
            8'h33: note_idx = 3'd5;
            8'h3B: note_idx = 3'd6;
            default: note_vld = 1'b0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_hit
            assign hit[gi] = (4'(gi) < cnt_q) && (stack_q[gi] == note_idx);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        do_make  = 1'b0;
        do_break = 1'b0;
        if (state_q == S_UPD) begin
            state_d = S_IDLE;
        end else if (bus.ready && !pop_q) begin
            // FIFO read pointer moves the cycle after a pop, so accepts are spaced by one.
            accept = 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (bus.data == 8'hF0)      state_d = S_BRK;
                    else if (bus.data == 8'hE0) state_d = S_EXT;
                    else begin
                        do_make = 1'b1;
                        state_d = S_UPD;
                    end
                end
                S_BRK: begin
                    do_break = 1'b1;
                    state_d  = S_UPD;
                end
                S_EXT:   state_d = (bus.data == 8'hF0) ? S_EXT_BRK : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.nextdata_n = ~(accept & clrn);

    always_comb begin
        stack_d = stack_q;
        cnt_d   = cnt_q;
        oct_d   = oct_q;
        hit_pos = '0;
        for (int i = STACK_DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) hit_pos = IW'(i);
        end
        if (do_make && note_vld) begin
            if (hit == '0) begin
                if (cnt_q == 4'(STACK_DEPTH)) begin
                    // Full: oldest key falls off the bottom.
                    for (int i = 0; i < STACK_DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
                    stack_d[STACK_DEPTH-1] = note_idx;
                end else begin
                    stack_d[cnt_q[IW-1:0]] = note_idx;
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end else if (do_make && bus.data == 8'h1A) begin
            if (oct_q != 2'b11) oct_d = oct_q - 2'd1;
        end else if (do_make && bus.data == 8'h22) begin
            if (oct_q != 2'b01) oct_d = oct_q + 2'd1;
        end else if (do_break && note_vld && hit != '0) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                if (IW'(i) >= hit_pos) stack_d[i] = stack_q[i+1];
            end
            cnt_d = cnt_q - 4'd1;
        end
    end

    assign top_idx = cnt_q - 4'd1;

    always_comb begin
        case (stack_q[top_idx[IW-1:0]])
            3'd0:    base = INC_C;
            3'd1:    base = INC_D;
            3'd2:    base = INC_E;
            3'd3:    base = INC_F;
            3'd4:    base = INC_G;
            3'd5:    base = INC_A;
            3'd6:    base = INC_B;
            default: base = 16'd0;
        endcase
        if (cnt_q == 4'd0)          freq_calc = 16'd0;
        else if (oct_q == 2'b11)    freq_calc = base >> 1;
        else if (oct_q == 2'b01)    freq_calc = base << 1;
        else                        freq_calc = base;
    end

`ifdef NOTE_GLIDE_EN
    logic [15:0] freq_tgt_q;
    logic [9:0]  div_q;
`endif

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            pop_q   <= 1'b0;
            cnt_q   <= 4'd0;
            oct_q   <= 2'b00;
            ovf_q   <= 1'b0;
            freq_q  <= 16'd0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 3'd0;
`ifdef NOTE_GLIDE_EN
            freq_tgt_q <= 16'd0;
            div_q      <= 10'd0;
`endif
        end else begin
            state_q <= state_d;
            pop_q   <= accept;
            cnt_q   <= cnt_d;
            oct_q   <= oct_d;
            stack_q <= stack_d;
            if (bus.overflow) ovf_q <= 1'b1;
`ifdef NOTE_GLIDE_EN
            div_q <= div_q + 10'd1;
            if (state_q == S_UPD) freq_tgt_q <= freq_calc;
            if ((state_q == S_UPD && freq_calc == 16'd0) || freq_tgt_q == 16'd0) begin
                freq_q <= 16'd0;
            end else if (div_q == 10'h3FF && freq_q != freq_tgt_q) begin
                freq_q <= (freq_q < freq_tgt_q) ? freq_q + 16'd1 : freq_q - 16'd1;
            end
`else
            if (state_q == S_UPD) freq_q <= freq_calc;
`endif
        end
    end

    assign freq     = freq_q;
    assign key_cnt  = cnt_q;
    assign octave   = oct_q;
    assign ovf_seen = ovf_q;
endmodule

// File: doc/ps2_note_ctrl.md
Name: ps2_note_ctrl

Overview:
Upstream stage of the tone generator. Consumes scan-code bytes from the PS/2 receiver FIFO through its ready/nextdata_n handshake. Tracks held note keys in a last-pressed-priority stack and applies an octave shift. Drives the 16-bit phase-increment word `freq` consumed by the sine generator; `freq` is 0 when no note is held.

Parameters:
- STACK_DEPTH, 4, maximum simultaneously tracked held keys (2..8).
- FS_HZ, 48000, sample rate used to derive the note table; table constants = round(f*65536/FS_HZ).

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- clrn  input  1  reset; synchronous, active-low.
- data  input  8  scan-code byte at the head of the PS/2 receiver FIFO.
- ready  input  1  FIFO non-empty; `data` is valid.
- overflow  input  1  FIFO overflow flag; informational, latched into `ovf_seen`.
- nextdata_n  output  1  active-low pop strobe to the FIFO.
- freq  output  16  phase increment to the sine generator.
- key_cnt  output  4  number of keys currently in the stack.
- octave  output  2  signed octave shift, -1..+1.
- ovf_seen  output  1  sticky; set when `overflow` is seen, cleared only by reset.

Behaviour:
- Reset (clrn=0 at posedge) values:
  - nextdata_n=1, freq=0, key_cnt=0, octave=0, ovf_seen=0.
  - Stack empty; FSM in IDLE.
- Handshake:
  - In IDLE with ready=1, the byte is latched and nextdata_n=0 for exactly one cycle (the accept cycle A).
  - nextdata_n returns to 1 in cycle A+1.
  - No new accept in A+1, because the FIFO pointer updates there. Maximum rate: one byte per 2 cycles.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen), UPD.
  - IDLE, byte F0 → BRK. IDLE, byte E0 → EXT. Any other byte in IDLE is processed as a make code → UPD.
  - BRK: next byte is processed as a break code → UPD.
  - EXT: byte F0 → EXT_BRK; any other byte is discarded → IDLE.
  - EXT_BRK: next byte is discarded → IDLE.
  - UPD lasts one cycle: `freq` is recomputed from the new stack top and octave → IDLE.
  - `freq` is valid in cycle A+2 after the final byte of a sequence is accepted.
- Note keys (make code → base increment at FS_HZ=48000):
  - A 1C → 357 (C4)
  - S 1B → 401
  - D 23 → 450
  - F 2B → 477
  - G 34 → 535
  - H 33 → 601 (A4)
  - J 3B → 674
- Make of a note key:
  - Key already in stack (typematic repeat): no change.
  - Otherwise pushed on top. If the stack is full, the oldest (bottom) entry is dropped and key_cnt stays at STACK_DEPTH.
- Break of a note key:
  - Entry removed; entries above it shift down to close the gap.
  - Break of a key not in the stack is ignored.
- Octave keys act on make only; their breaks are ignored.
  - Z (1A): octave-1, saturating at -1.
  - X (22): octave+1, saturating at +1.
- All other codes (including AA and FA) are ignored.
- freq rule:
  - Stack empty → 0.
  - Otherwise base(top) >>1 when octave=-1, unchanged at 0, <<1 at +1. The 16-bit result never overflows.
- Simultaneous events: overflow and ready in the same cycle are both honoured.
- Reset mid-sequence (e.g. after F0): the pending prefix is discarded and the stack cleared.

Optional Feature:
- Macro: NOTE_GLIDE_EN.
- Defined:
  - A `freq_tgt` register holds the computed value.
  - `freq` steps toward it by ±1 every 2^10 clk cycles until equal (portamento).
  - Reset sets both registers to 0.
  - A target of 0 forces `freq`=0 immediately (no glide to silence).
- Undefined: `freq` is loaded directly in UPD, as specified above.

Test Plan:
- Reset, then byte 1C with ready held until nextdata_n pulses → nextdata_n low 1 cycle; freq=357 two cycles after accept; key_cnt=1.
- Bytes 1C, 33, F0 33 → freq 357, then 601, then 357; key_cnt 1→2→1.
- Bytes 1C, 1B, 23, 2B, 34 with STACK_DEPTH=4 → key_cnt=4, freq=535; then F0 34 → freq=477; then F0 1C → freq unchanged (1C was dropped).
- Bytes 22, 22, 33 → octave=+1, freq=1202; then 1A 1A 1A → octave=-1, freq=300.
- Bytes E0 1C, then E0 F0 1C → freq stays 0, key_cnt=0; then 1C 1C 1C (typematic) → key_cnt=1.
- Bytes 1C, F0, then clrn=0 for 1 cycle, then 1C → after reset freq=0, octave=0; the final 1C is treated as a make, so freq=357.
